// File: rtl/lpf_decim_out.sv
// Decimating round/shift/saturate output stage for the lpf FIR, with a small valid/ready FIFO.
// Optional saturation event counter is built when SAT_COUNT_EN is defined.
module lpf_decim_out #(
    parameter int ACC_W      = 28,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    acc_valid_i,
    input  logic [7:0]              decim_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overflow_o,
    output logic [15:0]             sat_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [ACC_W:0] ROUND   = (ACC_W+1)'(64'sd1 <<< (SHIFT-1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W-1)));

    logic [7:0]              r_phase;
    logic [7:0]              r_decim;
    logic                    r_s1_val;
    logic signed [ACC_W:0]   r_s1;
    logic signed [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic                    r_overflow;

    logic [7:0]              w_m;
    logic                    w_keep;
    logic signed [ACC_W:0]   w_round;
    logic signed [ACC_W:0]   w_shifted;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic signed [OUT_W-1:0] w_sat_val;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;

    // Decimation: decim_i is only sampled when a group starts
    assign w_m    = (decim_i == 8'd0) ? 8'd1 : decim_i;
    assign w_keep = acc_valid_i && (r_phase == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_decim <= 8'd1;
        end else if (acc_valid_i) begin
            if (r_phase == 8'd0) begin
                r_decim <= w_m;
                r_phase <= (w_m == 8'd1) ? 8'd0 : 8'd1;
            end else if (r_phase == r_decim - 8'd1) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 8'd1;
            end
        end
    end

    assign w_round   = {acc_i[ACC_W-1], acc_i} + ROUND;
    assign w_shifted = w_round >>> SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_val <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_val <= w_keep;
            if (w_keep) r_s1 <= w_shifted;
        end
    end

    assign w_sat_hi  = r_s1 > SAT_MAX;
    assign w_sat_lo  = r_s1 < SAT_MIN;
    assign w_sat_val = w_sat_hi ? SAT_MAX[OUT_W-1:0] :
                       w_sat_lo ? SAT_MIN[OUT_W-1:0] : r_s1[OUT_W-1:0];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign valid_o = (r_count != '0);
    assign w_pop   = valid_o && ready_i;
    assign w_push  = r_s1_val && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_sat_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_s1_val && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign data_o     = valid_o ? r_mem[r_rptr] : '0;
    assign overflow_o = r_overflow;

`ifdef SAT_COUNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (r_s1_val && (w_sat_hi || w_sat_lo) && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt_o = r_sat_cnt;
`else
    assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lpf_decim_out.sv
// Directed bench for lpf_decim_out: rounding, saturation, decimation, FIFO full/overflow and reset flush.
module tb_lpf_decim_out;

    logic               clk;
    logic               rst;
    logic signed [27:0] acc_i;
    logic               acc_valid_i;
    logic [7:0]         decim_i;
    logic signed [15:0] data_o;
    logic               valid_o;
    logic               ready_i;
    logic               overflow_o;
    logic [15:0]        sat_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    int got[$];

    lpf_decim_out #(
        .ACC_W(28),
        .OUT_W(16),
        .SHIFT(12),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .acc_i(acc_i),
        .acc_valid_i(acc_valid_i),
        .decim_i(decim_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .overflow_o(overflow_o),
        .sat_cnt_o(sat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_acc(input logic signed [27:0] a);
        acc_i       = a;
        acc_valid_i = 1'b1;
        tick();
        acc_valid_i = 1'b0;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; acc_i = '0; acc_valid_i = 1'b0; decim_i = 8'd1; ready_i = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", $signed(data_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_satcnt", 32'(sat_cnt_o), 0);
        rst = 1'b0;

        // Rounding and two-cycle latency
        push_acc(28'sd6144);
        chk("t1_valid_n1", 32'(valid_o), 0);
        tick();
        chk("t1_valid_n2", 32'(valid_o), 1);
        chk("t1_data", $signed(data_o), 2);
        tick();
        chk("t1_valid_n3", 32'(valid_o), 0);

        // Saturation limits
        push_acc(28'sh7FFFFFF);
        push_acc(-28'sh8000000);
        chk("t2_pos_sat", $signed(data_o), 32767);
        push_acc(-28'sd2049);
        chk("t2_neg_min", $signed(data_o), -32768);
        tick();
        chk("t2_minus1", $signed(data_o), -1);
        tick();
        chk("t2_empty", 32'(valid_o), 0);
`ifdef SAT_COUNT_EN
        chk("t2_satcnt", 32'(sat_cnt_o), 1);
`else
        chk("t2_satcnt", 32'(sat_cnt_o), 0);
`endif

        // Decimation by 4, switching to 2 mid-group
        decim_i = 8'd4;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) decim_i = 8'd2;
            push_acc(28'(k << 12));
            if (valid_o) got.push_back(int'(data_o));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid_o) got.push_back(int'(data_o));
        end
        chk("t3_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t3_out0", got[0], 0);
            chk("t3_out1", got[1], 4);
            chk("t3_out2", got[2], 8);
            chk("t3_out3", got[3], 10);
        end
        decim_i = 8'd1;

        // Overflow with consumer stalled
        ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) push_acc(28'(k << 12));
        chk("t4_ovf_pre", 32'(overflow_o), 0);
        tick();
        chk("t4_ovf", 32'(overflow_o), 1);
        chk("t4_hold", $signed(data_o), 1);
        ready_i = 1'b1;
        chk("t4_d1", $signed(data_o), 1);
        tick();
        chk("t4_d2", $signed(data_o), 2);
        tick();
        chk("t4_d3", $signed(data_o), 3);
        tick();
        chk("t4_d4", $signed(data_o), 4);
        tick();
        chk("t4_empty", 32'(valid_o), 0);
        chk("t4_ovf_sticky", 32'(overflow_o), 1);

        // Reset with three buffered and one in flight
        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) push_acc(28'(k << 12));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(valid_o), 0);
        chk("t6_ovf", 32'(overflow_o), 0);
        tick();
        chk("t6_flushed", 32'(valid_o), 0);
        ready_i = 1'b1;
        decim_i = 8'd3;
        push_acc(28'(7 << 12));
        push_acc(28'(8 << 12));
        chk("t6_first", $signed(data_o), 7);
        push_acc(28'(9 << 12));
        chk("t6_gap", 32'(valid_o), 0);
        push_acc(28'(10 << 12));
        tick();
        chk("t6_second", $signed(data_o), 10);
        decim_i = 8'd1;
        tick();
        tick();

        // Full FIFO with simultaneous push and pop
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) push_acc(28'(k << 12));
        chk("t5_full_head", $signed(data_o), 1);
        ready_i = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("t5_d%0d", k), $signed(data_o), k);
        end
        tick();
        chk("t5_empty", 32'(valid_o), 0);
        chk("t5_ovf", 32'(overflow_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
